// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier product unloader.
// Optional feature macro: MUL_OUT_PARITY_EN (adds out_parity to product_unloader).
package mul_pkg;

   // Operand width of the multiplier core; products are twice this wide.
   localparam int WIDTH  = 32;
   localparam int PROD_W = 2 * WIDTH;

   // Width of the completed-product counter.
   localparam int CNT_W  = 16;

   // Unloader FSM: idle, sending first half, sending second half.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND_A = 2'd1,
      SEND_B = 2'd2
   } state_e;

endpackage : mul_pkg

// File: rtl/product_unloader.sv
// Splits each 2*WIDTH-bit signed product from the multiplier core into two
// WIDTH-bit words on a valid/ready stream. HI_FIRST selects which half leaves
// first. Back-to-back products are accepted during the second word's handshake
// so a continuous stream has no idle cycle between products.
// Optional feature macro: MUL_OUT_PARITY_EN adds out_parity, the registered
// XOR of out_data.
module product_unloader
   import mul_pkg::*;
#(
   parameter bit HI_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prod_valid,
   input  logic [PROD_W-1:0] prod_data,
   output logic              prod_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_last,
   output logic [CNT_W-1:0]  prod_count
`ifdef MUL_OUT_PARITY_EN
   ,
   output logic              out_parity
`endif
);

   state_e              state_q,      state_d;
   logic [PROD_W-1:0]   prod_q,       prod_d;
   logic [WIDTH-1:0]    out_data_q,   out_data_d;
   logic [CNT_W-1:0]    prod_count_q, prod_count_d;

   logic                prod_hs;
   logic                out_hs;

   // Handshake qualifiers for both sides of the unloader.
   assign prod_hs = prod_valid && prod_ready;
   assign out_hs  = out_valid  && out_ready;

   // Status outputs decoded straight from the state register, so reset clears them at once.
   assign out_valid  = (state_q != IDLE);
   assign out_last   = (state_q == SEND_B);
   assign out_data   = out_data_q;
   assign prod_count = prod_count_q;

   // Input ready: free in IDLE, busy in SEND_A, and able to chain a new product in SEND_B.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
      prod_ready = 1'b0;
      unique case (state_q)
         IDLE:    prod_ready = 1'b1;
         SEND_A:  prod_ready = 1'b0;
         SEND_B:  prod_ready = out_ready;
         default: prod_ready = 1'b0;
      endcase
   end

   // Next-state, product capture, output word selection and completed-product count.
   always_comb begin
      state_d      = state_q;
      prod_d       = prod_q;
      out_data_d   = out_data_q;
      prod_count_d = prod_count_q;

      unique case (state_q)
         IDLE: begin
            if (prod_hs) begin
               state_d    = SEND_A;
               prod_d     = prod_data;
               out_data_d = HI_FIRST ? prod_data[PROD_W-1:WIDTH] : prod_data[WIDTH-1:0];
            end
         end

         SEND_A: begin
            // The first word is already presented; on its handshake switch to the other half.
            if (out_hs) begin
               state_d    = SEND_B;
               out_data_d = HI_FIRST ? prod_q[WIDTH-1:0] : prod_q[PROD_W-1:WIDTH];
            end
         end

         SEND_B: begin
            if (out_hs) begin
               prod_count_d = prod_count_q + 1'b1;
               if (prod_hs) begin
                  // Chain the next product directly into its first word.
                  state_d    = SEND_A;
                  prod_d     = prod_data;
                  out_data_d = HI_FIRST ? prod_data[PROD_W-1:WIDTH] : prod_data[WIDTH-1:0];
               end else begin
                  state_d    = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State, product and output registers; asynchronous reset drops any in-flight product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         prod_q       <= '0;
         out_data_q   <= '0;
         prod_count_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q      <= state_d;
         prod_q       <= prod_d;
         out_data_q   <= out_data_d;
         prod_count_q <= prod_count_d;
      end
   end

`ifdef MUL_OUT_PARITY_EN
   logic out_parity_q;

   // Parity register loads together with out_data so the two always describe the same word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_parity_q <= 1'b0;
      end else begin
         out_parity_q <= ^out_data_d;
      end
   end

   assign out_parity = out_parity_q;
`endif

endmodule : product_unloader
